maze_move_ctrl: RTL

MAZE_MOVE_CTRL -- requirements
Module: maze_move_ctrl

---
 rtl/maze_move_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/maze_move_ctrl.sv
// Button front end for the maze game: synchronises and debounces five buttons, turns
// debounced presses into prioritised move codes and holds one move for the game core.
module maze_move_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move_code,
  output logic [4:0] btn_level,
  output logic       overflow
);

  localparam int unsigned NumBtn = 5;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  // Toggle fires on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] CodeNone  = 3'b000;
  localparam logic [2:0] CodeUp    = 3'b001;
  localparam logic [2:0] CodeDown  = 3'b010;
  localparam logic [2:0] CodeLeft  = 3'b011;
  localparam logic [2:0] CodeRight = 3'b100;
  localparam logic [2:0] CodeStart = 3'b101;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } buf_state_e;

  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] level_q, level_d;
  logic [NumBtn-1:0] level_hist_q;
  logic [CntW-1:0]   cnt_q [NumBtn];
  logic [CntW-1:0]   cnt_d [NumBtn];

  buf_state_e state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       ovf_q, ovf_d;

  logic [NumBtn-1:0] press;
  logic              ev_valid;
  logic [2:0]        ev_code;

  // Two-flop synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i]   = '0;
        level_d[i] = ~level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q      <= '0;
      level_hist_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q      <= level_d;
      level_hist_q <= level_q;
      for (int i = 0; i < NumBtn; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign press = level_q & ~level_hist_q;

  // Fixed priority; losers in the same cycle are dropped silently.
  always_comb begin
    ev_valid = 1'b1;
    ev_code  = CodeNone;
    if (press[4]) begin
      ev_code = CodeStart;
    end else if (press[3]) begin
      ev_code = CodeUp;
    end else if (press[2]) begin
      ev_code = CodeDown;
    end else if (press[1]) begin
      ev_code = CodeLeft;
    end else if (press[0]) begin
      ev_code = CodeRight;
    end else begin
      ev_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      code_q  <= CodeNone;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StEmpty: begin
        if (ev_valid) begin
          state_d = StFull;
          code_d  = ev_code;
        end
      end
      StFull: begin
        if (move_ready) begin
          if (ev_valid) begin
            code_d = ev_code;
          end else begin
            state_d = StEmpty;
            code_d  = CodeNone;
          end
        end else if (ev_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = StEmpty;
        code_d  = CodeNone;
      end
    endcase
  end

  assign move_valid = (state_q == StFull);
  assign move_code  = code_q;
  assign btn_level  = level_q;
  assign overflow   = ovf_q;

endmodule
